mem_port_arbiter: RTL and testbench

- Shares one unified single-port memory between two requesters: the IF stage (instruction fetch, read-only) and the MEM stage (load/store).
- Sequences each access through a fixed-latency memory.
- Returns data to the winning requester with a one-cycle valid pulse.
- Produces per-requester stall signals that the pipeline uses to freeze IF/ID and EX/MEM while an access is outstanding.

---
 rtl/mem_port_arbiter.sv | 167 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one fixed-latency single-port memory between the
// instruction-fetch (IF) and load/store (MEM) requesters. Each access runs
// IDLE -> ACCESS (MEM_LAT cycles) -> RESP (one-cycle valid pulse) -> IDLE.
// MEM wins simultaneous requests unless IF has already lost STARVE_MAX
// times in a row, in which case IF is forced through.
module mem_port_arbiter #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 32,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 3
) (
    input  logic              clk,
    input  logic              rst,
    // instruction fetch requester (read-only)
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_valid,
    // load/store requester
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_valid,
    // pipeline freeze controls
    output logic              stall_if,
    output logic              stall_mem,
    // memory side
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    // Both MEM_LAT and STARVE_MAX are limited to 1..15, so 4 bits suffice.
    localparam int CNT_W = 4;
    localparam logic [CNT_W-1:0] LAT_LOAD   = CNT_W'(MEM_LAT - 1);
    localparam logic [CNT_W-1:0] STREAK_MAX = CNT_W'(STARVE_MAX);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    typedef enum logic {
        OWN_IF  = 1'b0,
        OWN_MEM = 1'b1
    } owner_t;

    state_t             r_state;
    state_t             w_next_state;
    owner_t             r_owner;
    logic [CNT_W-1:0]   r_lat_cnt;
    logic [CNT_W-1:0]   r_streak;
    logic [ADDR_W-1:0]  r_addr;
    logic [DATA_W-1:0]  r_wdata;
    logic               r_we;
    logic [DATA_W-1:0]  r_if_rdata;
    logic [DATA_W-1:0]  r_mem_rdata;

    logic               w_any_req;
    logic               w_grant_mem;
    logic               w_start;
    logic               w_last;
    logic               w_access;
    logic               w_resp;

    assign w_any_req   = if_req | mem_req;
    // MEM wins a tie only while IF has not yet been passed over STARVE_MAX times.
    assign w_grant_mem = mem_req & (~if_req | (r_streak != STREAK_MAX));
    assign w_start     = (r_state == S_IDLE) & w_any_req;
    assign w_last      = (r_lat_cnt == '0);
    assign w_access    = (r_state == S_ACCESS);
    assign w_resp      = (r_state == S_RESP);

    // State register.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values; blocking (=) here would create order-dependent races.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic: launch on any request, leave ACCESS when the latency
    // counter runs out, always spend exactly one cycle in RESP.
    always_comb begin
        // NOTE: default assigned first so no path through the case leaves
        // w_next_state unassigned, which would infer a latch.
        w_next_state = r_state;
        case (r_state)
            S_IDLE:   if (w_any_req) w_next_state = S_ACCESS;
            S_ACCESS: if (w_last)    w_next_state = S_RESP;
            S_RESP:                  w_next_state = S_IDLE;
            default:                 w_next_state = S_IDLE;
        endcase
    end

    // Grant bookkeeping: latch the winner's request and load the latency counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_owner   <= OWN_IF;
            r_addr    <= '0;
            r_we      <= 1'b0;
            r_wdata   <= '0;
            r_lat_cnt <= '0;
        end else if (w_start) begin
            r_owner   <= w_grant_mem ? OWN_MEM : OWN_IF;
            r_addr    <= w_grant_mem ? mem_addr : if_addr;
            // Fetches are reads by definition, so we/wdata only come from MEM.
            r_we      <= w_grant_mem & mem_we;
            r_wdata   <= w_grant_mem ? mem_wdata : '0;
            r_lat_cnt <= LAT_LOAD;
        end else if (w_access && !w_last) begin
            r_lat_cnt <= r_lat_cnt - 1'b1;
        end
    end

    // Starvation streak: counts MEM grants taken while IF was waiting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_streak <= '0;
        end else if (w_start) begin
            if (w_grant_mem && if_req) begin
                if (r_streak != STREAK_MAX) r_streak <= r_streak + 1'b1;
            end else begin
                // IF grant, or MEM grant with nobody waiting behind it.
                r_streak <= '0;
            end
        end
    end

    // Read-data capture on the final ACCESS edge; stores return zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_if_rdata  <= '0;
            r_mem_rdata <= '0;
        end else if (w_access && w_last) begin
            if (r_owner == OWN_IF) begin
                r_if_rdata <= ram_rdata;
            end else begin
                r_mem_rdata <= r_we ? '0 : ram_rdata;
            end
        end
    end

    // Memory side is driven only during ACCESS, so ram_we can never be seen
    // without ram_en and the bus is quiet otherwise.
    assign ram_en    = w_access;
    assign ram_we    = w_access & r_we;
    assign ram_addr  = w_access ? r_addr  : '0;
    assign ram_wdata = w_access ? r_wdata : '0;

    assign if_valid  = w_resp & (r_owner == OWN_IF);
    assign mem_valid = w_resp & (r_owner == OWN_MEM);
    assign if_rdata  = r_if_rdata;
    assign mem_rdata = r_mem_rdata;

    assign stall_if  = if_req  & ~if_valid;
    assign stall_mem = mem_req & ~mem_valid;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed testbench for mem_port_arbiter. u_dut uses MEM_LAT=2 and
// STARVE_MAX=3; u_dut1 uses MEM_LAT=1 for the back-to-back fetch case.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_mem_port_arbiter;

    localparam int DW = 32;
    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;

    // u_dut (MEM_LAT=2)
    logic          if_req = 1'b0;
    logic [AW-1:0] if_addr = '0;
    logic [DW-1:0] if_rdata;
    logic          if_valid;
    logic          mem_req = 1'b0;
    logic          mem_we = 1'b0;
    logic [AW-1:0] mem_addr = '0;
    logic [DW-1:0] mem_wdata = '0;
    logic [DW-1:0] mem_rdata;
    logic          mem_valid;
    logic          stall_if;
    logic          stall_mem;
    logic          ram_en;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata = '0;

    // u_dut1 (MEM_LAT=1)
    logic          b_if_req = 1'b0;
    logic [AW-1:0] b_if_addr = '0;
    logic [DW-1:0] b_if_rdata;
    logic          b_if_valid;
    logic [DW-1:0] b_mem_rdata;
    logic          b_mem_valid;
    logic          b_stall_if;
    logic          b_stall_mem;
    logic          b_ram_en;
    logic          b_ram_we;
    logic [AW-1:0] b_ram_addr;
    logic [DW-1:0] b_ram_wdata;
    logic [DW-1:0] b_ram_rdata;

    int n_tests = 0;
    int n_fail  = 0;

    // Simple memory model for u_dut1: word = {addr[15:0], 16'hC0DE}.
    assign b_ram_rdata = {b_ram_addr[15:0], 16'hC0DE};

    always #5 clk = ~clk;

    mem_port_arbiter #(.DATA_W(DW), .ADDR_W(AW), .MEM_LAT(2), .STARVE_MAX(3)) u_dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_valid(mem_valid),
        .stall_if(stall_if), .stall_mem(stall_mem),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata)
    );

    mem_port_arbiter #(.DATA_W(DW), .ADDR_W(AW), .MEM_LAT(1), .STARVE_MAX(3)) u_dut1 (
        .clk(clk), .rst(rst),
        .if_req(b_if_req), .if_addr(b_if_addr), .if_rdata(b_if_rdata), .if_valid(b_if_valid),
        .mem_req(1'b0), .mem_we(1'b0), .mem_addr('0), .mem_wdata('0),
        .mem_rdata(b_mem_rdata), .mem_valid(b_mem_valid),
        .stall_if(b_stall_if), .stall_mem(b_stall_mem),
        .ram_en(b_ram_en), .ram_we(b_ram_we), .ram_addr(b_ram_addr), .ram_wdata(b_ram_wdata),
        .ram_rdata(b_ram_rdata)
    );

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one clock and settle just past the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [AW-1:0] exp_addr [5];
    logic          exp_is_if [5];

    initial begin
        exp_addr  = '{32'h90, 32'h90, 32'h90, 32'h30, 32'h90};
        exp_is_if = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

        // ---------------- reset state ----------------
        #12;
        check("rst_ram_en",    {31'b0, ram_en},    0);
        check("rst_ram_we",    {31'b0, ram_we},    0);
        check("rst_if_valid",  {31'b0, if_valid},  0);
        check("rst_mem_valid", {31'b0, mem_valid}, 0);
        check("rst_if_rdata",  if_rdata,  0);
        check("rst_mem_rdata", mem_rdata, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        step();

        // ---------------- single IF read ----------------
        if_req = 1'b1; if_addr = 32'h10; ram_rdata = 32'hDEADBEEF;
        #1;
        check("if_stall_pre", {31'b0, stall_if}, 1);
        check("if_idle_ram_en", {31'b0, ram_en}, 0);
        step();
        check("if_acc1_en",   {31'b0, ram_en}, 1);
        check("if_acc1_addr", ram_addr, 32'h10);
        check("if_acc1_we",   {31'b0, ram_we}, 0);
        check("if_acc1_stall",{31'b0, stall_if}, 1);
        step();
        check("if_acc2_en",   {31'b0, ram_en}, 1);
        check("if_acc2_valid",{31'b0, if_valid}, 0);
        step();
        check("if_resp_valid",{31'b0, if_valid}, 1);
        check("if_resp_data", if_rdata, 32'hDEADBEEF);
        check("if_resp_en",   {31'b0, ram_en}, 0);
        check("if_resp_stall",{31'b0, stall_if}, 0);
        check("if_resp_mval", {31'b0, mem_valid}, 0);
        if_req = 1'b0;
        step();
        check("if_idle_valid",{31'b0, if_valid}, 0);
        check("if_hold_data", if_rdata, 32'hDEADBEEF);

        // ---------------- MEM store ----------------
        mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h40; mem_wdata = 32'h12345678;
        for (int c = 0; c < 2; c++) begin
            step();
            check("st_en",    {31'b0, ram_en}, 1);
            check("st_we",    {31'b0, ram_we}, 1);
            check("st_addr",  ram_addr, 32'h40);
            check("st_wdata", ram_wdata, 32'h12345678);
        end
        step();
        check("st_valid", {31'b0, mem_valid}, 1);
        check("st_rdata", mem_rdata, 0);
        check("st_ifval", {31'b0, if_valid}, 0);
        check("st_resp_we", {31'b0, ram_we}, 0);
        mem_req = 1'b0; mem_we = 1'b0;
        step();

        // ---------------- simultaneous requests ----------------
        if_req = 1'b1; if_addr = 32'h20;
        mem_req = 1'b1; mem_addr = 32'h80; ram_rdata = 32'h11111111;
        step();
        check("sim_first_addr", ram_addr, 32'h80);
        step();
        step();
        check("sim_mem_valid", {31'b0, mem_valid}, 1);
        check("sim_mem_rdata", mem_rdata, 32'h11111111);
        check("sim_if_stall",  {31'b0, stall_if}, 1);
        mem_req = 1'b0; ram_rdata = 32'h22222222;
        step();
        check("sim_idle_ifv", {31'b0, if_valid}, 0);
        step();
        check("sim_second_addr", ram_addr, 32'h20);
        step();
        check("sim_mid_ifv", {31'b0, if_valid}, 0);
        step();
        check("sim_if_valid", {31'b0, if_valid}, 1);
        check("sim_if_rdata", if_rdata, 32'h22222222);
        if_req = 1'b0;
        step();

        // ---------------- starvation: MEM,MEM,MEM,IF,MEM ----------------
        if_req = 1'b1; if_addr = 32'h30;
        mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h90; ram_rdata = 32'h5A5A5A5A;
        for (int g = 0; g < 5; g++) begin
            step();
            check($sformatf("starve_g%0d_addr", g), ram_addr, exp_addr[g]);
            step();
            step();
            check($sformatf("starve_g%0d_ifv", g),  {31'b0, if_valid},  {31'b0, exp_is_if[g]});
            check($sformatf("starve_g%0d_memv", g), {31'b0, mem_valid}, {31'b0, ~exp_is_if[g]});
            if (g == 4) begin
                if_req = 1'b0; mem_req = 1'b0;
            end
            step();
        end

        // ---------------- reset mid-ACCESS ----------------
        if_req = 1'b1; if_addr = 32'h44; ram_rdata = 32'h77777777;
        step();
        step();
        check("rm_acc2_en", {31'b0, ram_en}, 1);
        rst = 1'b1;
        #1;
        check("rm_async_en",    {31'b0, ram_en}, 0);
        check("rm_async_rdata", if_rdata, 0);
        if_req = 1'b0;
        step();
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            step();
            check("rm_no_valid", {31'b0, if_valid | mem_valid}, 0);
            check("rm_no_en",    {31'b0, ram_en}, 0);
        end
        mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h60; ram_rdata = 32'h33333333;
        step();
        check("rm_fresh_addr", ram_addr, 32'h60);
        step();
        step();
        check("rm_fresh_valid", {31'b0, mem_valid}, 1);
        check("rm_fresh_rdata", mem_rdata, 32'h33333333);
        mem_req = 1'b0;
        step();

        // ---------------- back-to-back IF reads, MEM_LAT=1 ----------------
        b_if_req = 1'b1; b_if_addr = 32'h0;
        step();
        check("b2b_acc0_en",   {31'b0, b_ram_en}, 1);
        check("b2b_acc0_addr", b_ram_addr, 32'h0);
        step();
        check("b2b_v0",    {31'b0, b_if_valid}, 1);
        check("b2b_d0",    b_if_rdata, 32'h0000C0DE);
        b_if_addr = 32'h4;
        step();
        check("b2b_gap1",  {31'b0, b_if_valid}, 0);
        step();
        check("b2b_gap2",  {31'b0, b_if_valid}, 0);
        check("b2b_acc1_addr", b_ram_addr, 32'h4);
        step();
        check("b2b_v1",    {31'b0, b_if_valid}, 1);
        check("b2b_d1",    b_if_rdata, 32'h0004C0DE);
        b_if_req = 1'b0;
        step();
        check("b2b_after", {31'b0, b_if_valid}, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
